pipe_ctrl: RTL
==============

# pipe_ctrl

Parametrised pipeline control unit, successor to the fixed 6-bit stall controller. It converts per-stage stall requests into a prefix stall mask and sequences registered flush pulses with a redirect PC on exception/redirect requests. It also keeps a saturating stalled-cycle counter and a sticky stall-watchdog flag. It sits beside the pipeline and drives the stall/flush inputs of every stage register.

## Interface
- NSTAGE, 6: stall bus width; bit 0 = PC, bit k = stage k (1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
- FLUSH_CYCLES, 1: length of the flush pulse in cycles (≥1).
- CNT_W, 32: width of the stalled-cycle counter.
- WDOG_LIMIT, 1024: consecutive stall cycles that raise `stall_timeout`; 0 disables the watchdog.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq  in  NSTAGE-1  bit i-1 = stall request from stage i (level).
- excp_valid  in  1  redirect/exception request (level, one cycle is enough).
- excp_pc  in  32  redirect target, valid with `excp_valid`.
- perf_clr  in  1  synchronous clear of `stall_cycles`.
- stall  out  NSTAGE  stall mask (`StallBus`-compatible when NSTAGE=6).
- flush  out  1  registered flush pulse to all stage registers.
- new_pc  out  32  redirect target, valid while `flush`=1.
- stall_cycles  out  CNT_W  saturating count of cycles with `stall`≠0.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states: RUN, FLUSH. Reset state is RUN.
- Stall mask in RUN is combinational. Let h be the highest stage index with `stallreq[h-1]`=1. Then `stall` = bits 0..h set, for example ID gives 000111 and EX gives 001111. With no request, `stall`=0.
- In FLUSH, `stall`=0 regardless of `stallreq`. Flush dominates stall.
- RUN→FLUSH: on a clock edge with `excp_valid`=1, `excp_pc` is latched into `new_pc` and the flush counter is loaded with FLUSH_CYCLES-1. This happens even if a stall is active.
- In FLUSH:
  - `flush`=1.
  - The counter decrements each cycle.
  - At 0, return to RUN.
  - `excp_valid` is ignored, because the requesting stage is being flushed.
- `new_pc` holds its value after FLUSH ends. Consumers qualify it with `flush`.
- `stall_cycles`:
  - Increments when `stall`≠0.
  - Saturates at all-ones.
  - `perf_clr` has priority over increment.
- Watchdog:
  - A consecutive-stall counter increments while `stall`≠0 and clears when `stall`=0.
  - On reaching WDOG_LIMIT it sets `stall_timeout`.
  - `stall_timeout` clears only on reset.
  - The counter saturates at WDOG_LIMIT.

## Timing
- Reset values: `stall`=0, `flush`=0, `new_pc`=0, `stall_cycles`=0, `stall_timeout`=0, FSM=RUN, all counters 0.
- `stall` has 0-cycle latency from `stallreq`, so there is no register in that path.
- `excp_valid` sampled at edge t gives `flush`=1 and `new_pc`=`excp_pc` from t through t+FLUSH_CYCLES-1 (registered, 1-cycle latency).
- Simultaneous `excp_valid` and `stallreq` in RUN: `stall` follows the request in that cycle. The flush starts next cycle and forces `stall`=0.
- Back-to-back: `excp_valid` held high through FLUSH triggers a new flush only in the first RUN cycle after it. `flush` therefore drops for at least one cycle between requests.
- Reset asserted mid-FLUSH: outputs go to reset values immediately, asynchronously.
- Watchdog fires on the edge where the consecutive count reaches WDOG_LIMIT, i.e. after WDOG_LIMIT stalled cycles.

## Structure
- `lib/defines.vh`:
  - Holds `StallBus`, `Stop`, and state encodings `PC_RUN`/`PC_FLUSH`.
  - Add the default NSTAGE there as `StallBus`.
- Mask generation is a parametrised priority loop over `stallreq`.
- One natural sub-module is `sat_counter` (params WIDTH, MAX; inputs inc, clr). It is instantiated for `stall_cycles` and the watchdog count.

## Test plan
- Reset then idle: `stallreq`=0 → `stall`=000000, `flush`=0, `stall_cycles`=0.
- `stallreq`=00010 (ID) → `stall`=000111 same cycle. `stallreq`=00110 (ID+EX) → 001111. `stall_cycles` increments by 1 per cycle.
- `excp_valid`=1, `excp_pc`=0xBFC00380 for one cycle during an EX stall → next cycle `flush`=1, `new_pc`=0xBFC00380, `stall`=0. Back to RUN after 1 cycle. With FLUSH_CYCLES=3 the pulse lasts 3 cycles.
- `excp_valid` held 4 cycles (FLUSH_CYCLES=1) → `flush` pattern 0,1,0,1 across those cycles, with no consecutive flushes.
- WDOG_LIMIT=8:
  - Stall 7 cycles, release → `stall_timeout`=0.
  - Stall 8 cycles → `stall_timeout`=1, and it stays 1 after release until `rst`=0.
- CNT_W=4: stall 20 cycles → `stall_cycles`=15 (saturated). `perf_clr` pulse → 0. `rst` low mid-flush → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: default stall bus
// width, stall level meaning, FSM encodings and a width helper.
package pipe_ctrl_pkg;

  // Default number of stall bus bits: PC, IF, ID, EX, MEM, WB
  localparam int STALL_BUS = 6;

  // Level driven on a stall bit to hold the corresponding stage register
  localparam logic STOP = 1'b1;

  // Flush sequencer states, kept as plain constants for legacy users
  localparam logic [0:0] PC_RUN   = 1'b0;
  localparam logic [0:0] PC_FLUSH = 1'b1;

  // Bits needed to hold values 0..value-1, never less than one bit
  function automatic int safeClog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, otherwise step up until MAX is reached
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: turns per-stage stall requests into a prefix
// stall mask, sequences flush pulses with a redirect PC, and tracks
// stalled cycles plus a sticky stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE       = STALL_BUS,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NSTAGE-2:0] stallreq_i,
  input  logic              excp_valid_i,
  input  logic [31:0]       excp_pc_i,
  input  logic              perf_clr_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic              stall_timeout_o
);

  localparam int FC_W = safeClog2(FLUSH_CYCLES);
  localparam int WD_W = safeClog2(WDOG_LIMIT + 1);

  logic [0:0]        state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic              timeout_q, timeout_d;
  logic [NSTAGE-1:0] req_mask;
  logic              stall_any;
  logic [WD_W-1:0]   wdog_cnt;

  // Prefix mask: a request from stage k also holds every stage before it
  always_comb begin
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      acc         = acc | stallreq_i[k-1];
      req_mask[k] = acc;
    end
    req_mask[0] = acc;
  end

  // A flush in progress overrides any stall request
  assign stall_o   = (state_q == PC_RUN) ? req_mask : '0;
  assign stall_any = |stall_o;

  // Flush sequencer: latch the redirect target and count the pulse down;
  // requests arriving during a flush are dropped
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      PC_RUN: begin
        if (excp_valid_i) begin
          state_d  = PC_FLUSH;
          fcnt_d   = FC_W'(FLUSH_CYCLES - 1);
          new_pc_d = excp_pc_i;
        end
      end
      PC_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = PC_RUN;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = PC_RUN;
    endcase
  end

  // Watchdog fires on the edge that completes WDOG_LIMIT consecutive
  // stalled cycles and then stays set until reset
  always_comb begin
    timeout_d = timeout_q;
    if ((WDOG_LIMIT != 0) && stall_any && (wdog_cnt == WD_W'(WDOG_LIMIT - 1))) begin
      timeout_d = 1'b1;
    end
  end

  // Sequencer and watchdog flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= PC_RUN;
      fcnt_q    <= '0;
      new_pc_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      new_pc_q  <= new_pc_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_stall_cycles (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (stall_any),
    .clr_i   (perf_clr_i),
    .count_o (stall_cycles_o)
  );

  sat_counter #(
    .WIDTH (WD_W),
    .MAX   (WD_W'(WDOG_LIMIT))
  ) u_wdog_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (stall_any),
    .clr_i   (!stall_any),
    .count_o (wdog_cnt)
  );

  assign flush_o         = (state_q == PC_FLUSH);
  assign new_pc_o        = new_pc_q;
  assign stall_timeout_o = timeout_q;

endmodule
